// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Word-addressed 32-bit memory behind a request/ready handshake for a
// multicycle control path. A request accepted in IDLE passes through a
// programmable number of wait cycles, a single ACCESS cycle and a one-cycle
// DONE completion strobe. A bad request (misaligned, out of range, or both a
// read and a write at once) skips the access and completes through ERROR.
//
// Parameters
//   ADDR_W    word-address width; the storage holds 2^ADDR_W words
//   WAIT      wait cycles inserted before each access (0..15)
//
// Ports
//   cclk      in   clock; all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   MemRead   in   read request
//   MemWrite  in   write request
//   Addr      in   byte address of the request
//   WriteData in   store data, used only for writes
//   ReadData  out  registered read data; holds until the next good read
//   MemReady  out  one-cycle completion strobe
//   Busy      out  high whenever the responder is not idle
//   Fault     out  one-cycle error strobe, coincident with MemReady
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic        cclk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        Busy,
    output logic        Fault
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    // The wait state ends when the counter, cleared on entry, reaches WAIT-1.
    localparam logic       HAS_WAIT  = (WAIT > 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t              state_q;
    logic [3:0]          wait_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                write_q;
    logic [31:0]         rdata_q;
    logic                ready_q;
    logic                fault_q;
    logic                busy_q;

    logic [31:0]         mem [0:DEPTH-1];

    logic                req_s;
    logic                misaligned_s;
    logic                out_of_range_s;
    logic                both_s;
    logic                bad_req_s;

    // Classify the request presented on the inputs this cycle.
    always_comb begin
        req_s          = MemRead | MemWrite;
        both_s         = MemRead & MemWrite;
        misaligned_s   = (Addr[1:0] != 2'b00);
        // Any address bit above the word index makes the request out of range.
        out_of_range_s = ((Addr >> (ADDR_W + 2)) != 32'd0);
        bad_req_s      = misaligned_s | out_of_range_s | both_s;
    end

    // Control FSM with registered MemReady / Fault / Busy.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        addr_q     <= Addr[ADDR_W+1:2];
                        wdata_q    <= WriteData;
                        write_q    <= MemWrite;
                        wait_cnt_q <= 4'd0;
                        busy_q     <= 1'b1;
                        if (bad_req_s) begin
                            // Faulted requests complete next cycle, no access.
                            state_q <= ST_ERROR;
                            ready_q <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (HAS_WAIT) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_DONE;
                    ready_q <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_ERROR: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage write port; contents survive reset, but reset blocks a write
    // whose ACCESS edge coincides with it.
    always_ff @(posedge cclk) begin
        if (!rst && (state_q == ST_ACCESS) && write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Read data register; only a completing good read updates it.
    always_ff @(posedge cclk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if ((state_q == ST_ACCESS) && !write_q) begin
            rdata_q <= mem[addr_q];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = ready_q;
    assign Fault    = fault_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. A WAIT=2 instance runs a table of
// transactions plus hand-written reset-abort and input-change sequences; a
// WAIT=0 instance runs a continuously held read to check back-to-back timing.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic        cclk;
    logic        rst;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        fault;

    logic        mem_read0;
    logic        mem_write0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic [31:0] rdata0;
    logic        ready0;
    logic        busy0;
    logic        fault0;

    int total;
    int bad;

    mem_responder #(.ADDR_W(8), .WAIT(2)) dut (
        .cclk      (cclk),
        .rst       (rst),
        .MemRead   (mem_read),
        .MemWrite  (mem_write),
        .Addr      (addr),
        .WriteData (wdata),
        .ReadData  (rdata),
        .MemReady  (ready),
        .Busy      (busy),
        .Fault     (fault)
    );

    mem_responder #(.ADDR_W(8), .WAIT(0)) dut0 (
        .cclk      (cclk),
        .rst       (rst),
        .MemRead   (mem_read0),
        .MemWrite  (mem_write0),
        .Addr      (addr0),
        .WriteData (wdata0),
        .ReadData  (rdata0),
        .MemReady  (ready0),
        .Busy      (busy0),
        .Fault     (fault0)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          cyc;
        logic        flt;
        logic [31:0] rd_exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge with the responder idle: issues one
    // request for one cycle and checks completion cycle, Fault and ReadData.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int exp_cyc, input logic exp_flt,
                           input logic [31:0] exp_rd);
        int cyc;
        chk({name, "/idle_busy"}, {31'd0, busy}, 32'd0);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        @(negedge cclk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        cyc = 1;
        chk({name, "/busy_c1"}, {31'd0, busy}, 32'd1);
        while (!ready && cyc < 20) begin
            @(negedge cclk);
            cyc++;
        end
        chk({name, "/ready_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "/fault"}, {31'd0, fault}, {31'd0, exp_flt});
        chk({name, "/rdata"}, rdata, exp_rd);
        @(negedge cclk);
        chk({name, "/ready_drop"}, {31'd0, ready}, 32'd0);
        chk({name, "/busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 1, 1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 4, 1'b0, 32'hCAFE_F00D};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h55AA_55AA, 4, 1'b0, 32'hCAFE_F00D};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 1'b1, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4, 1'b0, 32'h55AA_55AA};
        vecs[9]  = '{1'b0, 1'b1, 32'h8000_0010, 32'h0101_0101, 1, 1'b1, 32'h55AA_55AA};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4, 1'b0, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0034, 32'h3434_3434, 4, 1'b0, 32'hDEAD_BEEF};

        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = 32'd0;
        wdata      = 32'd0;
        mem_read0  = 1'b0;
        mem_write0 = 1'b0;
        addr0      = 32'd0;
        wdata0     = 32'd0;
        repeat (3) @(negedge cclk);

        chk("rst/rdata", rdata, 32'd0);
        chk("rst/ready", {31'd0, ready}, 32'd0);
        chk("rst/busy",  {31'd0, busy},  32'd0);
        chk("rst/fault", {31'd0, fault}, 32'd0);

        // Held read on the zero-wait instance, asserted in the first cycle
        // after reset release: completions in cycles 2, 5, 8.
        rst       = 1'b0;
        mem_read0 = 1'b1;
        addr0     = 32'd0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge cclk);
            chk($sformatf("b2b/ready_c%0d", c), {31'd0, ready0}, {31'd0, (c % 3) == 2});
            chk($sformatf("b2b/busy_c%0d", c),  {31'd0, busy0},  {31'd0, (c % 3) != 0});
            chk($sformatf("b2b/fault_c%0d", c), {31'd0, fault0}, 32'd0);
        end
        mem_read0 = 1'b0;
        repeat (4) @(negedge cclk);

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a,
                    vecs[i].wd, vecs[i].cyc, vecs[i].flt, vecs[i].rd_exp);
        end

        // Request inputs change during WAIT; only the cycle-0 capture counts.
        mem_write = 1'b1;
        addr      = 32'h0000_0030;
        wdata     = 32'h0F0F_0F0F;
        @(negedge cclk);
        mem_write = 1'b0;
        addr      = 32'h0000_0034;
        wdata     = 32'hFFFF_FFFF;
        chk("chg/busy_c1", {31'd0, busy}, 32'd1);
        @(negedge cclk);
        mem_write = 1'b1;
        chk("chg/ready_c2", {31'd0, ready}, 32'd0);
        @(negedge cclk);
        mem_write = 1'b0;
        mem_read  = 1'b1;
        chk("chg/ready_c3", {31'd0, ready}, 32'd0);
        @(negedge cclk);
        mem_read  = 1'b0;
        chk("chg/ready_c4", {31'd0, ready}, 32'd1);
        chk("chg/fault_c4", {31'd0, fault}, 32'd0);
        @(negedge cclk);
        chk("chg/busy_c5", {31'd0, busy}, 32'd0);
        @(negedge cclk);
        chk("chg/busy_c6", {31'd0, busy}, 32'd0);
        run_txn("chg_rd30", 1'b1, 1'b0, 32'h0000_0030, 32'd0, 4, 1'b0, 32'h0F0F_0F0F);
        run_txn("chg_rd34", 1'b1, 1'b0, 32'h0000_0034, 32'd0, 4, 1'b0, 32'h3434_3434);

        // Reset during the ACCESS cycle of a write suppresses it.
        run_txn("rw_first", 1'b0, 1'b1, 32'h0000_0008, 32'hAAAA_5555, 4, 1'b0, 32'h3434_3434);
        mem_write = 1'b1;
        addr      = 32'h0000_0008;
        wdata     = 32'h1111_1111;
        @(negedge cclk);
        mem_write = 1'b0;
        @(negedge cclk);
        @(negedge cclk);
        chk("rw/busy_access", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge cclk);
        chk("rw/ready_c4", {31'd0, ready}, 32'd0);
        chk("rw/busy_c4",  {31'd0, busy},  32'd0);
        chk("rw/rdata_rst", rdata, 32'd0);
        @(negedge cclk);
        chk("rw/ready_c5", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        run_txn("rw_read08", 1'b1, 1'b0, 32'h0000_0008, 32'd0, 4, 1'b0, 32'hAAAA_5555);

        repeat (2) @(negedge cclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
